reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  In-order completion buffer beside reservation_station: allocates the RSV_ID tag a dispatched instr carries into an RS,
//  captures results broadcast on the CDB, serves operand lookups to dispatch, retires entries in program order to the regfile.
//  Sits downstream of RS/exec (consumes CDB), upstream of regfile writeback; tag source for dispatch.
// PARAMETERS
//  N_ENTRIES_W  4  log2 entry count (16); must be <= RSV_ID_W
//  N_LOOKUP     2  operand lookup ports (one per RS operand)
// PORTS
//  clk          in   1                  clock, all state on posedge
//  nrst         in   1                  reset, asynchronous, active-low
//  alloc_valid  in   1                  dispatch requests an entry
//  alloc_dest   in   REG_ADDR_W         architectural dest reg of new entry
//  alloc_ready  out  1                  entry available
//  alloc_id     out  RSV_ID_W           tag granted (tail index, zero-extended)
//  lk_id        in   N_LOOKUP*RSV_ID_W  tags to look up
//  lk_done      out  N_LOOKUP           entry i result present
//  lk_data      out  N_LOOKUP*DATA_W    entry i result
//  cdb_valid    in   1                  CDB broadcast valid
//  cdb          in   CDB_W              {tag[RSV_ID_W], data[DATA_W]}, tag at [DATA_W+:RSV_ID_W]
//  flush        in   1                  synchronous clear of all entries
//  commit_valid out  1                  head entry complete
//  commit_id    out  RSV_ID_W           head tag
//  commit_dest  out  REG_ADDR_W         head dest reg
//  commit_data  out  DATA_W             head result
//  commit_ready in   1                  regfile accepts commit
// BEHAVIOUR
//  - Circular buffer, head/tail ptrs N_ENTRIES_W+1 bits (wrap bit); full = idx equal & wrap differ; empty = ptrs equal.
//  - Reset (nrst=0, async): all entries invalid, head=tail=0; alloc_ready=1, alloc_id=0, commit_valid=0, commit_*=0, lk_done=0.
//  - Alloc: alloc_valid&alloc_ready -> entry[tail]={valid=1,done=0,dest}, tail+1 next edge; alloc_id=tail combinationally.
//  - alloc_ready = !full from registered ptrs only; no comb path from commit_ready (full + same-cycle commit still refuses alloc).
//  - CDB: cdb_valid, entry[tag] valid & !done -> done=1, data=cdb data next edge. Tag of invalid or done entry: ignored.
//  - CDB tag bits above N_ENTRIES_W ignored.
//  - Commit: commit_valid = entry[head].valid & done; commit_* from head. valid&ready -> entry invalid, head+1.
//  - commit_valid, once high, holds with stable data until accepted or flush.
//  - Latency: CDB at edge n -> commit_valid at n+1 earliest; alloc at n -> lookup/commit visible from n+1.
//  - Simultaneous: alloc+commit+CDB in one cycle all take effect; CDB to entry allocated same cycle ignored (was free).
//  - Wrap: tail/head roll 15->0 with wrap toggle; ids reuse after commit.
//  - Flush: priority over alloc/CDB/commit that cycle; next edge all invalid, head=tail=0; alloc/commit handshakes that
//    cycle are void.
//  - Lookup: comb; lk_done[i] = entry[lk_id[i]].valid & done; lk_data = its data; invalid entry -> done=0, data=0.
//  - Reset mid-operation: immediate return to reset state; in-flight handshakes lost.
// CONFIGURATION
//  ROB_BYPASS_EN defined: lookup also matches same-cycle CDB.
//   - cdb_valid & tag==lk_id[i] & entry valid -> lk_done[i]=1, lk_data[i]=cdb data, same cycle.
//  Undefined: lookup sees registered state only; CDB result visible one cycle later.
//  Commit path identical either way.
// STRUCTURE
//  fcpu_pkg: REG_ADDR_W; CDB_W; typedef struct packed {valid, done, dest, data} rob_entry_t.
//  fcpu_pkg: function cdb_tag(cdb) / cdb_data(cdb) slice helpers, shared with reservation_station.
//  Sub-module rob_ptr: wrap-bit pointer register with inc/clr and async reset, instantiated for head and tail.
//  Entry array, CDB capture, lookup mux, commit mux stay in reorder_buffer.
// TESTING
//  1. Reset, 16 allocs dest=1..16, no commit_ready -> alloc_id 0..15, alloc_ready=0 after 16th, 17th alloc not taken.
//  2. Out-of-order CDB: CDB tag3=0x33 then tag0=0xAA, commit_ready=1 -> commit id0 data 0xAA only; id3 waits for 1,2.
//  3. Backpressure: head done, commit_ready=0 for 5 cycles -> commit_valid/id/data stable; commit at cycle 6, head+1.
//  4. Wrap: 40 alloc/complete/commit pairs -> alloc_id sequence 0..15,0..15,0..7; no entry lost or duplicated.
//  5. Bypass: lk_id=2, entry 2 pending, CDB tag2=0x55 -> ROB_BYPASS_EN: lk_done=1, lk_data=0x55 same cycle;
//     else lk_done=1 next cycle.
//  6. Flush with alloc+commit+CDB asserted, then nrst pulse mid-stream -> next cycle empty, alloc_id=0, commit_valid=0.

Source files
------------

// File: rtl/fcpu_pkg.sv
// Shared definitions for the out-of-order core: bus widths, the reorder buffer
// entry layout and the CDB slice helpers used by the reorder buffer and the
// reservation station.
package fcpu_pkg;

   localparam int RSV_ID_W   = 5;
   localparam int DATA_W     = 32;
   localparam int REG_ADDR_W = 5;
   localparam int CDB_W      = RSV_ID_W + DATA_W;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic [REG_ADDR_W-1:0] dest;
      logic [DATA_W-1:0]     data;
   } rob_entry_t;

   // Result tag carried in the upper field of a CDB word.
   function automatic logic [RSV_ID_W-1:0] cdb_tag(input logic [CDB_W-1:0] cdb_word);
      return cdb_word[DATA_W +: RSV_ID_W];
   endfunction

   // Result data carried in the lower field of a CDB word.
   function automatic logic [DATA_W-1:0] cdb_data(input logic [CDB_W-1:0] cdb_word);
      return cdb_word[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/rob_ptr.sv
// Circular-buffer pointer with an extra wrap bit so that full and empty can be
// told apart when the index bits are equal. clr has priority over inc.
module rob_ptr #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         clr,
   input  logic         inc,
   output logic [W:0]   ptr
);

   logic [W:0] ptr_reg;
   logic [W:0] ptr_next;

   // Next pointer: clear wins, otherwise step by one and let the wrap bit toggle.
   always_comb begin
      ptr_next = ptr_reg;
      if (clr) begin
         ptr_next = '0;
      end else if (inc) begin
         ptr_next = ptr_reg + (W+1)'(1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

   assign ptr = ptr_reg;

endmodule

// File: rtl/reorder_buffer.sv
// In-order completion buffer. Hands out tags to dispatch, captures results
// from the CDB, answers operand lookups and retires the oldest completed
// entry to the register file.
// Optional feature: define ROB_BYPASS_EN to let lookups also see the CDB
// result broadcast in the same cycle.
module reorder_buffer
   import fcpu_pkg::*;
#(
   parameter int N_ENTRIES_W = 4,
   parameter int N_LOOKUP    = 2
) (
   input  logic                         clk,
   input  logic                         nrst,
   input  logic                         alloc_valid,
   input  logic [REG_ADDR_W-1:0]        alloc_dest,
   output logic                         alloc_ready,
   output logic [RSV_ID_W-1:0]          alloc_id,
   input  logic [N_LOOKUP*RSV_ID_W-1:0] lk_id,
   output logic [N_LOOKUP-1:0]          lk_done,
   output logic [N_LOOKUP*DATA_W-1:0]   lk_data,
   input  logic                         cdb_valid,
   input  logic [CDB_W-1:0]             cdb,
   input  logic                         flush,
   output logic                         commit_valid,
   output logic [RSV_ID_W-1:0]          commit_id,
   output logic [REG_ADDR_W-1:0]        commit_dest,
   output logic [DATA_W-1:0]            commit_data,
   input  logic                         commit_ready
);

   localparam int N_ENTRIES = 1 << N_ENTRIES_W;

   logic [N_ENTRIES_W:0]   head_ptr;
   logic [N_ENTRIES_W:0]   tail_ptr;
   logic [N_ENTRIES_W-1:0] head_idx;
   logic [N_ENTRIES_W-1:0] tail_idx;
   logic [N_ENTRIES_W-1:0] cdb_idx;
   logic [RSV_ID_W-1:0]    cdb_tag_w;
   logic [DATA_W-1:0]      cdb_data_w;
   logic                   full;
   logic                   alloc_fire;
   logic                   commit_fire;
   rob_entry_t             entry_q [N_ENTRIES];
   rob_entry_t             head_entry;

   assign head_idx   = head_ptr[N_ENTRIES_W-1:0];
   assign tail_idx   = tail_ptr[N_ENTRIES_W-1:0];
   assign cdb_tag_w  = cdb_tag(cdb);
   assign cdb_data_w = cdb_data(cdb);
   assign cdb_idx    = cdb_tag_w[N_ENTRIES_W-1:0];

   // Readiness depends on registered pointers only, so a commit in the same
   // cycle never opens a slot combinationally. A flush voids both handshakes.
   assign full        = (head_idx == tail_idx) && (head_ptr[N_ENTRIES_W] != tail_ptr[N_ENTRIES_W]);
   assign alloc_ready = !full;
   assign alloc_id    = RSV_ID_W'(tail_idx);
   assign alloc_fire  = alloc_valid && alloc_ready && !flush;
   assign commit_fire = commit_valid && commit_ready && !flush;

   rob_ptr #(.W(N_ENTRIES_W)) u_head_ptr (
      .clk  (clk),
      .nrst (nrst),
      .clr  (flush),
      .inc  (commit_fire),
      .ptr  (head_ptr)
   );

   rob_ptr #(.W(N_ENTRIES_W)) u_tail_ptr (
      .clk  (clk),
      .nrst (nrst),
      .clr  (flush),
      .inc  (alloc_fire),
      .ptr  (tail_ptr)
   );

   genvar gi;
   generate
      for (gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
         rob_entry_t entry_reg;
         rob_entry_t entry_next;

         // Entry update: flush clears, alloc claims a free slot, CDB completes a
         // pending slot (a slot claimed this cycle was free, so CDB misses it),
         // commit releases the head.
         always_comb begin
            entry_next = entry_reg;
            if (flush) begin
               entry_next.valid = 1'b0;
               entry_next.done  = 1'b0;
            end else begin
               if (alloc_fire && (tail_idx == N_ENTRIES_W'(gi))) begin
                  entry_next.valid = 1'b1;
                  entry_next.done  = 1'b0;
                  entry_next.dest  = alloc_dest;
               end else if (cdb_valid && (cdb_idx == N_ENTRIES_W'(gi)) &&
                            entry_reg.valid && !entry_reg.done) begin
                  entry_next.done  = 1'b1;
                  entry_next.data  = cdb_data_w;
               end
               if (commit_fire && (head_idx == N_ENTRIES_W'(gi))) begin
                  entry_next.valid = 1'b0;
                  entry_next.done  = 1'b0;
               end
            end
         end

         // Entry storage.
         always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
               entry_reg <= '0;
            end else begin
               entry_reg <= entry_next;
            end
         end

         assign entry_q[gi] = entry_reg;
      end

      for (gi = 0; gi < N_LOOKUP; gi++) begin : g_lookup
         logic [RSV_ID_W-1:0]    lk_tag;
         logic [N_ENTRIES_W-1:0] lk_idx;
         logic                   lk_done_w;
         logic [DATA_W-1:0]      lk_data_w;

         assign lk_tag = lk_id[gi*RSV_ID_W +: RSV_ID_W];
         assign lk_idx = lk_tag[N_ENTRIES_W-1:0];

         // Operand lookup: completed entries report their result, anything else
         // reports not-done with zero data.
         always_comb begin
            lk_done_w = entry_q[lk_idx].valid & entry_q[lk_idx].done;
            lk_data_w = lk_done_w ? entry_q[lk_idx].data : '0;
`ifdef ROB_BYPASS_EN
            if (!lk_done_w && entry_q[lk_idx].valid && cdb_valid && (cdb_idx == lk_idx)) begin
               lk_done_w = 1'b1;
               lk_data_w = cdb_data_w;
            end
`endif
         end

         assign lk_done[gi]                 = lk_done_w;
         assign lk_data[gi*DATA_W +: DATA_W] = lk_data_w;

         if (RSV_ID_W > N_ENTRIES_W) begin : g_lk_hi
            logic unused_lk_hi;
            assign unused_lk_hi = ^lk_tag[RSV_ID_W-1:N_ENTRIES_W];
         end
      end

      if (RSV_ID_W > N_ENTRIES_W) begin : g_cdb_hi
         logic unused_cdb_hi;
         assign unused_cdb_hi = ^cdb_tag_w[RSV_ID_W-1:N_ENTRIES_W];
      end
   endgenerate

   // Commit port presents the head; payload is zeroed while nothing is ready.
   assign head_entry   = entry_q[head_idx];
   assign commit_valid = head_entry.valid & head_entry.done;
   assign commit_id    = RSV_ID_W'(head_idx);
   assign commit_dest  = commit_valid ? head_entry.dest : '0;
   assign commit_data  = commit_valid ? head_entry.data : '0;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: scenario tasks drive stimulus and
// check inline; a commit monitor pops the in-order scoreboard on each retire.
module tb_reorder_buffer;
   import fcpu_pkg::*;

   localparam int NL = 2;
   localparam int NE = 16;

   logic                     clk;
   logic                     nrst;
   logic                     alloc_valid;
   logic [REG_ADDR_W-1:0]    alloc_dest;
   logic                     alloc_ready;
   logic [RSV_ID_W-1:0]      alloc_id;
   logic [NL*RSV_ID_W-1:0]   lk_id;
   logic [NL-1:0]            lk_done;
   logic [NL*DATA_W-1:0]     lk_data;
   logic                     cdb_valid;
   logic [CDB_W-1:0]         cdb;
   logic                     flush;
   logic                     commit_valid;
   logic [RSV_ID_W-1:0]      commit_id;
   logic [REG_ADDR_W-1:0]    commit_dest;
   logic [DATA_W-1:0]        commit_data;
   logic                     commit_ready;

   int checks  = 0;
   int errors  = 0;
   int commits = 0;
   int sb_q[$];
   logic [REG_ADDR_W-1:0] model_dest [NE];
   logic [DATA_W-1:0]     model_data [NE];

   reorder_buffer #(.N_ENTRIES_W(4), .N_LOOKUP(NL)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .alloc_valid  (alloc_valid),
      .alloc_dest   (alloc_dest),
      .alloc_ready  (alloc_ready),
      .alloc_id     (alloc_id),
      .lk_id        (lk_id),
      .lk_done      (lk_done),
      .lk_data      (lk_data),
      .cdb_valid    (cdb_valid),
      .cdb          (cdb),
      .flush        (flush),
      .commit_valid (commit_valid),
      .commit_id    (commit_id),
      .commit_dest  (commit_dest),
      .commit_data  (commit_data),
      .commit_ready (commit_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Commit monitor: every accepted retire must match the oldest scoreboard entry.
   always @(negedge clk) begin
      #2;
      if (nrst && !flush && commit_valid && commit_ready) begin
         checks++;
         commits++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected: id=%0d data=%h required no commit", commit_id, commit_data);
         end else begin
            automatic int id = sb_q.pop_front();
            if (commit_id !== RSV_ID_W'(id) || commit_dest !== model_dest[id] || commit_data !== model_data[id]) begin
               errors++;
               $display("FAIL commit_order: id=%0d dest=%0d data=%h required id=%0d dest=%0d data=%h",
                        commit_id, commit_dest, commit_data, id, model_dest[id], model_data[id]);
            end else begin
               $display("commit id=%0d dest=%0d data=%h", commit_id, commit_dest, commit_data);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_idle();
      alloc_valid  = 1'b0;
      alloc_dest   = '0;
      cdb_valid    = 1'b0;
      cdb          = '0;
      flush        = 1'b0;
      commit_ready = 1'b0;
   endtask

   task automatic set_cdb(input int tag, input logic [DATA_W-1:0] d);
      cdb_valid = 1'b1;
      cdb       = {RSV_ID_W'(tag), d};
   endtask

   task automatic set_lk(input int a, input int b);
      lk_id = {RSV_ID_W'(b), RSV_ID_W'(a)};
   endtask

   task automatic push_alloc(input int id, input int dest);
      sb_q.push_back(id);
      model_dest[id] = REG_ADDR_W'(dest);
      model_data[id] = '0;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      drive_idle();
      set_lk(0, 0);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (alloc_ready !== 1'b1 || alloc_id !== '0) begin
         errors++;
         $display("FAIL reset_alloc: ready=%0b id=%0d required ready=1 id=0", alloc_ready, alloc_id);
      end
      checks++;
      if (commit_valid !== 1'b0 || commit_id !== '0 || commit_dest !== '0 || commit_data !== '0) begin
         errors++;
         $display("FAIL reset_commit: valid=%0b id=%0d dest=%0d data=%h required all 0",
                  commit_valid, commit_id, commit_dest, commit_data);
      end
      checks++;
      if (lk_done !== 2'b00 || lk_data !== '0) begin
         errors++;
         $display("FAIL reset_lookup: done=%b data=%h required 0", lk_done, lk_data);
      end
      @(negedge clk);
      nrst = 1'b1;
      sb_q.delete();
   endtask

   task automatic test_fill();
      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         alloc_valid = 1'b1;
         alloc_dest  = REG_ADDR_W'(i + 1);
         #1;
         checks++;
         if (i < 16) begin
            if (alloc_ready !== 1'b1 || alloc_id !== RSV_ID_W'(i)) begin
               errors++;
               $display("FAIL fill_alloc: ready=%0b id=%0d required ready=1 id=%0d", alloc_ready, alloc_id, i);
            end
            push_alloc(i, i + 1);
         end else if (alloc_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: ready=%0b required 0", alloc_ready);
         end
      end
      @(negedge clk);
      alloc_valid = 1'b0;
      #1;
      checks++;
      if (alloc_ready !== 1'b0 || alloc_id !== '0 || commit_valid !== 1'b0) begin
         errors++;
         $display("FAIL fill_after: ready=%0b id=%0d cvalid=%0b required 0 0 0", alloc_ready, alloc_id, commit_valid);
      end
   endtask

   task automatic test_out_of_order();
      int start;
      @(negedge clk);
      set_cdb(3, 32'h33);
      model_data[3] = 32'h33;
      @(negedge clk);
      set_cdb(3, 32'h77);
      #1;
      checks++;
      if (commit_valid !== 1'b0) begin
         errors++;
         $display("FAIL ooo_head_wait: commit_valid=%0b required 0", commit_valid);
      end
      @(negedge clk);
      set_cdb(0, 32'hAA);
      model_data[0] = 32'hAA;
      commit_ready = 1'b1;
      alloc_valid  = 1'b1;
      alloc_dest   = 5'd31;
      @(negedge clk);
      cdb_valid = 1'b0;
      #1;
      checks++;
      if (alloc_ready !== 1'b0 || commit_valid !== 1'b1 || commit_id !== 5'd0 || commit_data !== 32'hAA) begin
         errors++;
         $display("FAIL ooo_commit0: aready=%0b cvalid=%0b id=%0d data=%h required 0 1 0 aa",
                  alloc_ready, commit_valid, commit_id, commit_data);
      end
      @(negedge clk);
      alloc_valid = 1'b0;
      set_lk(3, 3);
      #1;
      checks++;
      if (alloc_ready !== 1'b1 || alloc_id !== 5'd0 || commit_valid !== 1'b0 || commit_id !== 5'd1) begin
         errors++;
         $display("FAIL ooo_after0: aready=%0b aid=%0d cvalid=%0b cid=%0d required 1 0 0 1",
                  alloc_ready, alloc_id, commit_valid, commit_id);
      end
      checks++;
      if (lk_done !== 2'b11 || lk_data[31:0] !== 32'h33 || lk_data[63:32] !== 32'h33) begin
         errors++;
         $display("FAIL ooo_lookup3: done=%b data=%h required 11 both 33", lk_done, lk_data);
      end
      start = commits;
      set_cdb(1, 32'h11);
      model_data[1] = 32'h11;
      @(negedge clk);
      set_cdb(2, 32'h22);
      model_data[2] = 32'h22;
      @(negedge clk);
      cdb_valid = 1'b0;
      for (int w = 0; w < 10 && commits - start < 3; w++) @(negedge clk);
      #3;
      checks++;
      if (commits - start !== 3) begin
         errors++;
         $display("FAIL ooo_drain: commits=%0d required 3", commits - start);
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      commit_ready = 1'b0;
      set_cdb(4, 32'h44);
      model_data[4] = 32'h44;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         cdb_valid    = 1'b0;
         commit_ready = (c == 5);
         #1;
         checks++;
         if (commit_valid !== 1'b1 || commit_id !== 5'd4 || commit_dest !== 5'd5 || commit_data !== 32'h44) begin
            errors++;
            $display("FAIL bp_hold cycle %0d: valid=%0b id=%0d dest=%0d data=%h required 1 4 5 44",
                     c, commit_valid, commit_id, commit_dest, commit_data);
         end
      end
      @(negedge clk);
      commit_ready = 1'b0;
      #1;
      checks++;
      if (commit_valid !== 1'b0 || commit_id !== 5'd5) begin
         errors++;
         $display("FAIL bp_advance: valid=%0b id=%0d required 0 5", commit_valid, commit_id);
      end
   endtask

   task automatic test_wrap();
      int start;
      // Complete and retire everything still outstanding (ids 5..15).
      for (int k = 5; k < 16; k++) begin
         @(negedge clk);
         commit_ready = 1'b1;
         set_cdb(k, DATA_W'(32'h100 + k));
         model_data[k] = DATA_W'(32'h100 + k);
      end
      @(negedge clk);
      cdb_valid = 1'b0;
      for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(negedge clk);
      #3;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_predrain: outstanding=%0d required 0", sb_q.size());
      end
      // Pipelined alloc / complete / commit, all three in one cycle at steady state.
      start = commits;
      for (int t = 0; t < 42; t++) begin
         @(negedge clk);
         commit_ready = 1'b1;
         alloc_valid  = (t < 40);
         alloc_dest   = REG_ADDR_W'(t);
         cdb_valid    = 1'b0;
         if (t >= 1 && t <= 40) begin
            automatic int k   = t - 1;
            automatic int idx = k % 16;
            automatic logic [DATA_W-1:0] d = $urandom;
            set_cdb((k % 2 == 1) ? idx + 16 : idx, d);
            model_data[idx] = d;
         end
         #1;
         if (t < 40) begin
            checks++;
            if (alloc_ready !== 1'b1 || alloc_id !== RSV_ID_W'(t % 16)) begin
               errors++;
               $display("FAIL wrap_alloc t=%0d: ready=%0b id=%0d required 1 %0d", t, alloc_ready, alloc_id, t % 16);
            end
            push_alloc(t % 16, t);
         end
      end
      @(negedge clk);
      alloc_valid = 1'b0;
      cdb_valid   = 1'b0;
      for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(negedge clk);
      #3;
      checks++;
      if (commits - start !== 40 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_count: commits=%0d outstanding=%0d required 40 0", commits - start, sb_q.size());
      end
      commit_ready = 1'b0;
   endtask

   task automatic test_bypass();
      logic [NL-1:0]     exp_done;
      logic [DATA_W-1:0] exp_data;
      // Tail sits at index 8; allocate 8..15,0,1,2 with a CDB to 2 in its alloc cycle.
      for (int a = 0; a < 11; a++) begin
         automatic int id = (8 + a) % 16;
         @(negedge clk);
         alloc_valid = 1'b1;
         alloc_dest  = REG_ADDR_W'(a + 3);
         cdb_valid   = 1'b0;
         if (a == 10) set_cdb(2, 32'h99);
         #1;
         checks++;
         if (alloc_ready !== 1'b1 || alloc_id !== RSV_ID_W'(id)) begin
            errors++;
            $display("FAIL byp_alloc: ready=%0b id=%0d required 1 %0d", alloc_ready, alloc_id, id);
         end
         push_alloc(id, a + 3);
      end
      @(negedge clk);
      alloc_valid = 1'b0;
      cdb_valid   = 1'b0;
      set_lk(2, 2);
      #1;
      checks++;
      if (lk_done !== 2'b00 || lk_data !== '0) begin
         errors++;
         $display("FAIL byp_same_cycle_alloc: done=%b data=%h required 00 0", lk_done, lk_data);
      end
      @(negedge clk);
      set_cdb(2, 32'h55);
      model_data[2] = 32'h55;
`ifdef ROB_BYPASS_EN
      exp_done = 2'b11;
      exp_data = 32'h55;
`else
      exp_done = 2'b00;
      exp_data = 32'h0;
`endif
      #1;
      checks++;
      if (lk_done !== exp_done || lk_data[31:0] !== exp_data || lk_data[63:32] !== exp_data) begin
         errors++;
         $display("FAIL byp_same_cycle: done=%b data=%h required %b %h", lk_done, lk_data, exp_done, exp_data);
      end
      @(negedge clk);
      cdb_valid = 1'b0;
      #1;
      checks++;
      if (lk_done !== 2'b11 || lk_data[31:0] !== 32'h55 || lk_data[63:32] !== 32'h55 || commit_valid !== 1'b0) begin
         errors++;
         $display("FAIL byp_next_cycle: done=%b data=%h cvalid=%0b required 11 55 0", lk_done, lk_data, commit_valid);
      end
   endtask

   task automatic test_flush_reset();
      int start;
      @(negedge clk);
      set_cdb(8, 32'h88);
      model_data[8] = 32'h88;
      @(negedge clk);
      cdb_valid = 1'b0;
      #1;
      checks++;
      if (commit_valid !== 1'b1 || commit_id !== 5'd8) begin
         errors++;
         $display("FAIL flush_pre: valid=%0b id=%0d required 1 8", commit_valid, commit_id);
      end
      @(negedge clk);
      flush        = 1'b1;
      alloc_valid  = 1'b1;
      alloc_dest   = 5'd7;
      commit_ready = 1'b1;
      set_cdb(9, 32'h99);
      @(negedge clk);
      sb_q.delete();
      drive_idle();
      set_lk(2, 8);
      #1;
      checks++;
      if (alloc_ready !== 1'b1 || alloc_id !== '0 || commit_valid !== 1'b0 || commit_id !== '0 || lk_done !== 2'b00) begin
         errors++;
         $display("FAIL flush_after: aready=%0b aid=%0d cvalid=%0b cid=%0d lk=%b required 1 0 0 0 00",
                  alloc_ready, alloc_id, commit_valid, commit_id, lk_done);
      end
      // Refill partially, then pull reset in the middle of a cycle.
      for (int a = 0; a < 4; a++) begin
         @(negedge clk);
         alloc_valid = 1'b1;
         alloc_dest  = REG_ADDR_W'(a + 20);
         cdb_valid   = 1'b0;
         if (a == 2) set_cdb(0, 32'hC0);
         if (a == 3) set_cdb(1, 32'hC1);
         if (a == 3) begin
            #3;
            nrst = 1'b0;
            set_lk(0, 0);
            #1;
            checks++;
            if (alloc_ready !== 1'b1 || alloc_id !== '0 || commit_valid !== 1'b0 || lk_done !== 2'b00) begin
               errors++;
               $display("FAIL reset_mid: aready=%0b aid=%0d cvalid=%0b lk=%b required 1 0 0 00",
                        alloc_ready, alloc_id, commit_valid, lk_done);
            end
         end
      end
      sb_q.delete();
      @(negedge clk);
      drive_idle();
      nrst = 1'b1;
      #1;
      checks++;
      if (alloc_id !== '0 || commit_valid !== 1'b0 || commit_id !== '0) begin
         errors++;
         $display("FAIL reset_release: aid=%0d cvalid=%0b cid=%0d required 0 0 0", alloc_id, commit_valid, commit_id);
      end
      // Normal operation resumes from tag 0.
      start = commits;
      @(negedge clk);
      alloc_valid = 1'b1;
      alloc_dest  = 5'd9;
      #1;
      checks++;
      if (alloc_ready !== 1'b1 || alloc_id !== '0) begin
         errors++;
         $display("FAIL resume_alloc: ready=%0b id=%0d required 1 0", alloc_ready, alloc_id);
      end
      push_alloc(0, 9);
      @(negedge clk);
      alloc_valid  = 1'b0;
      commit_ready = 1'b1;
      set_cdb(0, 32'hD0);
      model_data[0] = 32'hD0;
      @(negedge clk);
      cdb_valid = 1'b0;
      for (int w = 0; w < 10 && sb_q.size() != 0; w++) @(negedge clk);
      #3;
      checks++;
      if (commits - start !== 1 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL resume_commit: commits=%0d outstanding=%0d required 1 0", commits - start, sb_q.size());
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_out_of_order();
      test_backpressure();
      test_wrap();
      test_bypass();
      test_flush_reset();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
